// File: rtl/sgmii_an_pkg.sv
// rtl/sgmii_an_pkg.sv - shared types and 8b/10b code constants for SGMII auto-negotiation receive
package sgmii_an_pkg;

    typedef enum logic [2:0] {
        ABILITY_DETECT = 3'd0,
        ACK_DETECT     = 3'd1,
        COMPLETE_ACK   = 3'd2,
        IDLE_DETECT    = 3'd3,
        LINK_OK        = 3'd4
    } an_state_t;

    typedef enum logic [1:0] {
        P_HUNT   = 2'd0,
        P_CODE   = 2'd1,
        P_CFG_LO = 2'd2,
        P_CFG_HI = 2'd3
    } parser_state_t;

    localparam logic [7:0] K28_5 = 8'hBC;
    localparam logic [7:0] D21_5 = 8'hB5;
    localparam logic [7:0] D2_2  = 8'h42;
    localparam logic [7:0] D16_2 = 8'h50;
    localparam logic [7:0] D5_6  = 8'hC5;
    localparam int         CFG_ACK_BIT = 14;

    // Ability comparisons treat words differing only in the ACK bit as equal.
    function automatic logic [15:0] cfg_strip_ack(input logic [15:0] word);
        logic [15:0] w;
        w = word;
        w[CFG_ACK_BIT] = 1'b0;
        return w;
    endfunction

endpackage

// File: rtl/sgmii_os_parser.sv
// rtl/sgmii_os_parser.sv - ordered-set parser: decoded byte stream to registered config/idle events
module sgmii_os_parser
    import sgmii_an_pkg::*;
(
    input  logic        clock_i,
    input  logic        reset_i,
    input  logic        rx_valid_i,
    input  logic [7:0]  rx_data_i,
    input  logic        rx_is_k_i,
    input  logic        rx_code_err_i,
    output logic        cfg_evt_o,
    output logic [15:0] cfg_word_o,
    output logic        idle_evt_o
);

    parser_state_t state_q, state_d;
    logic [7:0]    lo_q, lo_d;
    logic [15:0]   cfg_word_q, cfg_word_d;
    logic          cfg_evt_q, cfg_evt_d;
    logic          idle_evt_q, idle_evt_d;
    logic          is_comma;
    logic          accept;

    assign is_comma = rx_is_k_i && (rx_data_i == K28_5);
    assign accept   = rx_valid_i && !rx_code_err_i && !is_comma;

    always_ff @(posedge clock_i) begin
        if (reset_i) begin
            state_q <= P_HUNT;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        if (rx_valid_i) begin
            if (rx_code_err_i) begin
                state_d = P_HUNT;
            end else if (is_comma) begin
                state_d = P_CODE;
            end else begin
                case (state_q)
                    P_CODE:   state_d = (!rx_is_k_i && (rx_data_i == D21_5 || rx_data_i == D2_2))
                                        ? P_CFG_LO : P_HUNT;
                    P_CFG_LO: state_d = rx_is_k_i ? P_HUNT : P_CFG_HI;
                    default:  state_d = P_HUNT;
                endcase
            end
        end
    end

    always_comb begin
        cfg_evt_d  = 1'b0;
        idle_evt_d = 1'b0;
        lo_d       = lo_q;
        cfg_word_d = cfg_word_q;
        if (accept) begin
            case (state_q)
                P_CODE:   idle_evt_d = !rx_is_k_i && (rx_data_i == D16_2 || rx_data_i == D5_6);
                P_CFG_LO: if (!rx_is_k_i) lo_d = rx_data_i;
                P_CFG_HI: begin
                    if (!rx_is_k_i) begin
                        cfg_evt_d  = 1'b1;
                        cfg_word_d = {rx_data_i, lo_q};
                    end
                end
                default: ;
            endcase
        end
    end

    // Events are registered, giving one cycle latency from the last byte of a set.
    always_ff @(posedge clock_i) begin
        if (reset_i) begin
            lo_q       <= '0;
            cfg_word_q <= '0;
            cfg_evt_q  <= 1'b0;
            idle_evt_q <= 1'b0;
        end else begin
            lo_q       <= lo_d;
            cfg_word_q <= cfg_word_d;
            cfg_evt_q  <= cfg_evt_d;
            idle_evt_q <= idle_evt_d;
        end
    end

    assign cfg_evt_o  = cfg_evt_q;
    assign cfg_word_o = cfg_word_q;
    assign idle_evt_o = idle_evt_q;

endmodule

// File: rtl/sgmii_an_rx.sv
// rtl/sgmii_an_rx.sv - SGMII auto-negotiation receive arbitration; link timer enabled by SGMII_AN_LINK_TIMER_EN
module sgmii_an_rx
    import sgmii_an_pkg::*;
#(
    parameter int MATCH_COUNT       = 3,
    parameter int LINK_TIMER_CYCLES = 200000
) (
    input  logic        clock_i,
    input  logic        reset_i,
    input  logic        an_restart_i,
    input  logic        rx_valid_i,
    input  logic [7:0]  rx_data_i,
    input  logic        rx_is_k_i,
    input  logic        rx_code_err_i,
    output logic [15:0] partner_config_o,
    output logic        config_valid_o,
    output logic        tx_send_config_o,
    output logic        tx_ack_o,
    output logic        link_up_o,
    output logic [2:0]  an_state_o
);

    localparam int             CNT_W   = $clog2(MATCH_COUNT + 1);
    localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(MATCH_COUNT);

    logic        cfg_evt, idle_evt;
    logic [15:0] cfg_word;

    an_state_t        state_q, state_d;
    logic [CNT_W-1:0] abil_cnt_q, abil_cnt_d, ack_cnt_q, ack_cnt_d, idle_cnt_q, idle_cnt_d;
    logic [CNT_W-1:0] abil_cnt_ev, ack_cnt_ev;
    logic [15:0]      last_word_q, last_word_d, partner_q, partner_d;
    logic             same_abil, same_full, abil_match, ack_match, idle_match;
    logic             clear_cnt, timer_done;

    sgmii_os_parser u_parser (
        .clock_i       (clock_i),
        .reset_i       (reset_i),
        .rx_valid_i    (rx_valid_i),
        .rx_data_i     (rx_data_i),
        .rx_is_k_i     (rx_is_k_i),
        .rx_code_err_i (rx_code_err_i),
        .cfg_evt_o     (cfg_evt),
        .cfg_word_o    (cfg_word),
        .idle_evt_o    (idle_evt)
    );

    assign clear_cnt = an_restart_i || (rx_valid_i && rx_code_err_i);

    // A zero run count means no valid previous word, so last_word_q is ignored.
    always_comb begin
        same_abil   = (abil_cnt_q != '0) && (cfg_strip_ack(cfg_word) == cfg_strip_ack(last_word_q));
        same_full   = (ack_cnt_q != '0) && (cfg_word == last_word_q);
        abil_cnt_ev = !same_abil ? CNT_W'(1)
                    : (abil_cnt_q == CNT_MAX) ? CNT_MAX : abil_cnt_q + CNT_W'(1);
        if (!cfg_word[CFG_ACK_BIT]) begin
            ack_cnt_ev = '0;
        end else if (!same_full) begin
            ack_cnt_ev = CNT_W'(1);
        end else begin
            ack_cnt_ev = (ack_cnt_q == CNT_MAX) ? CNT_MAX : ack_cnt_q + CNT_W'(1);
        end
        abil_match = cfg_evt && (abil_cnt_ev == CNT_MAX);
        ack_match  = cfg_evt && (ack_cnt_ev == CNT_MAX);
        idle_match = (idle_cnt_q == CNT_MAX);
    end

    always_comb begin
        abil_cnt_d  = abil_cnt_q;
        ack_cnt_d   = ack_cnt_q;
        idle_cnt_d  = idle_cnt_q;
        last_word_d = last_word_q;
        partner_d   = partner_q;
        if (clear_cnt) begin
            abil_cnt_d = '0;
            ack_cnt_d  = '0;
            idle_cnt_d = '0;
        end else if (cfg_evt) begin
            abil_cnt_d  = abil_cnt_ev;
            ack_cnt_d   = ack_cnt_ev;
            idle_cnt_d  = '0;
            last_word_d = cfg_word;
        end else if (idle_evt) begin
            idle_cnt_d = (idle_cnt_q == CNT_MAX) ? CNT_MAX : idle_cnt_q + CNT_W'(1);
        end
        if (!an_restart_i && state_q == ABILITY_DETECT && abil_match && cfg_word != 16'h0000) begin
            partner_d = cfg_word;
        end
    end

    always_ff @(posedge clock_i) begin
        if (reset_i) begin
            abil_cnt_q  <= '0;
            ack_cnt_q   <= '0;
            idle_cnt_q  <= '0;
            last_word_q <= '0;
            partner_q   <= '0;
        end else begin
            abil_cnt_q  <= abil_cnt_d;
            ack_cnt_q   <= ack_cnt_d;
            idle_cnt_q  <= idle_cnt_d;
            last_word_q <= last_word_d;
            partner_q   <= partner_d;
        end
    end

`ifdef SGMII_AN_LINK_TIMER_EN
    // Restarts on every state change so each timed state waits its full period.
    logic [17:0] timer_q;
    assign timer_done = (timer_q >= 18'(LINK_TIMER_CYCLES - 1));

    always_ff @(posedge clock_i) begin
        if (reset_i || (state_d != state_q)) begin
            timer_q <= '0;
        end else if (!timer_done) begin
            timer_q <= timer_q + 18'd1;
        end
    end
`else
    logic unused_timer_cfg;
    assign unused_timer_cfg = (LINK_TIMER_CYCLES == 0);
    assign timer_done       = 1'b1;
`endif

    always_ff @(posedge clock_i) begin
        if (reset_i) begin
            state_q <= ABILITY_DETECT;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        if (an_restart_i) begin
            state_d = ABILITY_DETECT;
        end else begin
            case (state_q)
                ABILITY_DETECT: begin
                    if (abil_match && cfg_word != 16'h0000) state_d = ACK_DETECT;
                end
                ACK_DETECT: begin
                    if (cfg_evt && cfg_word == 16'h0000) begin
                        state_d = ABILITY_DETECT;
                    end else if (ack_match && cfg_strip_ack(cfg_word) == cfg_strip_ack(partner_q)) begin
                        state_d = COMPLETE_ACK;
                    end else if (abil_match && cfg_strip_ack(cfg_word) != cfg_strip_ack(partner_q)) begin
                        state_d = ABILITY_DETECT;
                    end
                end
                COMPLETE_ACK: begin
                    if (cfg_evt && cfg_word == 16'h0000) state_d = ABILITY_DETECT;
                    else if (timer_done)                 state_d = IDLE_DETECT;
                end
                IDLE_DETECT: begin
                    if (cfg_evt)                        state_d = ABILITY_DETECT;
                    else if (idle_match && timer_done)  state_d = LINK_OK;
                end
                LINK_OK: begin
                    if (cfg_evt) state_d = ABILITY_DETECT;
                end
                default: state_d = ABILITY_DETECT;
            endcase
        end
    end

    always_comb begin
        tx_send_config_o = 1'b1;
        tx_ack_o         = 1'b0;
        link_up_o        = 1'b0;
        case (state_q)
            ACK_DETECT, COMPLETE_ACK: tx_ack_o = 1'b1;
            IDLE_DETECT:              tx_send_config_o = 1'b0;
            LINK_OK: begin
                tx_send_config_o = 1'b0;
                link_up_o        = 1'b1;
            end
            default: ;
        endcase
    end

    assign partner_config_o = partner_q;
    assign config_valid_o   = cfg_evt;
    assign an_state_o       = state_q;

endmodule

// File: tb/tb_sgmii_an_rx.sv
// tb/tb_sgmii_an_rx.sv - randomized self-checking bench for sgmii_an_rx against an ordered-set level model
module tb_sgmii_an_rx;

`ifdef SGMII_AN_LINK_TIMER_EN
    localparam int LTC = 100;
`else
    localparam int LTC = 200000;
`endif

    logic        clock, reset, an_restart, rx_valid, rx_is_k, rx_code_err;
    logic [7:0]  rx_data;
    logic [15:0] partner_config;
    logic        config_valid, tx_send_config, tx_ack, link_up;
    logic [2:0]  an_state;

    sgmii_an_rx #(.MATCH_COUNT(3), .LINK_TIMER_CYCLES(LTC)) dut (
        .clock_i          (clock),
        .reset_i          (reset),
        .an_restart_i     (an_restart),
        .rx_valid_i       (rx_valid),
        .rx_data_i        (rx_data),
        .rx_is_k_i        (rx_is_k),
        .rx_code_err_i    (rx_code_err),
        .partner_config_o (partner_config),
        .config_valid_o   (config_valid),
        .tx_send_config_o (tx_send_config),
        .tx_ack_o         (tx_ack),
        .link_up_o        (link_up),
        .an_state_o       (an_state)
    );

    int checks = 0;
    int errors = 0;
    int cfg_pulses = 0;
    int cyc = 0;
    int t_ca = -1;
    int t_lu = -1;
    bit arm = 0;
    bit gap_en = 0;

    // Model kept at ordered-set granularity: last words seen since the last clear.
    int          m_state;
    logic [15:0] m_partner;
    logic [15:0] m_hist[$];
    int          m_idle_run;
    int          m_cfg_count = 0;

    initial clock = 1'b0;
    always #4 clock = ~clock;
    always @(posedge clock) cyc++;
    always @(negedge clock) if (config_valid === 1'b1) cfg_pulses++;
    always @(negedge clock) begin
        if (arm) begin
            if (t_ca < 0 && an_state == 3'd2) t_ca = cyc;
            if (t_lu < 0 && link_up === 1'b1) t_lu = cyc;
        end
    end

    function automatic logic [15:0] strip(input logic [15:0] w);
        return w & 16'hBFFF;
    endfunction

    task automatic model_clear();
        m_hist.delete();
        m_idle_run = 0;
    endtask

    task automatic model_cfg(input logic [15:0] w);
        bit abil, ack;
        m_cfg_count++;
        m_idle_run = 0;
        m_hist.push_back(w);
        if (m_hist.size() > 3) void'(m_hist.pop_front());
        abil = (m_hist.size() == 3) && strip(m_hist[0]) == strip(m_hist[1]) && strip(m_hist[1]) == strip(m_hist[2]);
        ack  = (m_hist.size() == 3) && m_hist[0] == m_hist[1] && m_hist[1] == m_hist[2] && w[14];
        case (m_state)
            0: if (abil && w != 16'h0) begin m_partner = w; m_state = 1; end
            1: begin
                if (w == 16'h0) m_state = 0;
                else if (ack && strip(w) == strip(m_partner)) m_state = 3;
                else if (abil && strip(w) != strip(m_partner)) m_state = 0;
            end
            default: m_state = 0;
        endcase
    endtask

    task automatic model_idle();
        m_idle_run++;
        if (m_state == 3 && m_idle_run >= 3) m_state = 4;
    endtask

    task automatic idle_cycles(input int n);
        repeat (n) begin
            @(posedge clock); #1;
            rx_valid = 1'b0; rx_code_err = 1'b0; an_restart = 1'b0; rx_is_k = 1'b0;
        end
    endtask

    task automatic send_byte(input logic [7:0] d, input logic k, input logic err);
        if (gap_en && $urandom_range(0, 3) == 0) begin
            @(posedge clock); #1;
            rx_valid = 1'b0; rx_code_err = 1'b0;
        end
        @(posedge clock); #1;
        rx_valid = 1'b1; rx_data = d; rx_is_k = k; rx_code_err = err;
    endtask

    task automatic send_cfg(input logic [15:0] w, input int err_pos, input bit settle);
        logic [7:0] b[4];
        b[0] = 8'hBC;
        b[1] = $urandom_range(0, 1) ? 8'hB5 : 8'h42;
        b[2] = w[7:0];
        b[3] = w[15:8];
        for (int i = 0; i < 4; i++) send_byte(b[i], i == 0, i == err_pos);
        if (err_pos >= 0) model_clear();
        else model_cfg(w);
        if (settle) idle_cycles(5);
    endtask

    task automatic send_idle(input int err_pos);
        send_byte(8'hBC, 1'b1, err_pos == 0);
        send_byte($urandom_range(0, 1) ? 8'h50 : 8'hC5, 1'b0, err_pos == 1);
        if (err_pos >= 0) model_clear();
        else model_idle();
        idle_cycles(5);
    endtask

    task automatic do_reset();
        @(posedge clock); #1;
        reset = 1'b1; rx_valid = 1'b0; an_restart = 1'b0; rx_code_err = 1'b0;
        repeat (3) @(posedge clock);
        #1 reset = 1'b0;
        m_state = 0; m_partner = 16'h0;
        model_clear();
    endtask

    task automatic test_reset();
        do_reset();
        checks += 6;
        if (partner_config !== 16'h0) begin errors++; $display("FAIL reset_partner got %h want 0000", partner_config); end
        if (config_valid !== 1'b0) begin errors++; $display("FAIL reset_cfg_valid got %b want 0", config_valid); end
        if (tx_send_config !== 1'b1) begin errors++; $display("FAIL reset_tx_send_config got %b want 1", tx_send_config); end
        if (tx_ack !== 1'b0) begin errors++; $display("FAIL reset_tx_ack got %b want 0", tx_ack); end
        if (link_up !== 1'b0) begin errors++; $display("FAIL reset_link_up got %b want 0", link_up); end
        if (an_state !== 3'd0) begin errors++; $display("FAIL reset_an_state got %0d want 0", an_state); end
    endtask

    task automatic test_ability_ack_link();
        int p0;
        do_reset();
        p0 = cfg_pulses;
        repeat (3) send_cfg(16'h9801, -1, 1);
        checks += 4;
        if (cfg_pulses - p0 !== 3) begin errors++; $display("FAIL c1_pulses got %0d want 3", cfg_pulses - p0); end
        if (partner_config !== 16'h9801) begin errors++; $display("FAIL c1_partner got %h want 9801", partner_config); end
        if (tx_ack !== 1'b1) begin errors++; $display("FAIL c1_tx_ack got %b want 1", tx_ack); end
        if (an_state !== 3'd1) begin errors++; $display("FAIL c1_state got %0d want 1", an_state); end
        repeat (3) send_cfg(16'hD801, -1, 1);
        checks += 2;
        if (an_state !== 3'd3) begin errors++; $display("FAIL c2_state got %0d want 3", an_state); end
        if (tx_send_config !== 1'b0) begin errors++; $display("FAIL c2_tx_send_config got %b want 0", tx_send_config); end
        repeat (3) send_idle(-1);
        checks += 3;
        if (an_state !== 3'd4) begin errors++; $display("FAIL i2_state got %0d want 4", an_state); end
        if (link_up !== 1'b1) begin errors++; $display("FAIL i2_link_up got %b want 1", link_up); end
        if (tx_send_config !== 1'b0) begin errors++; $display("FAIL i2_tx_send_config got %b want 0", tx_send_config); end
    endtask

    task automatic test_link_restart();
        send_cfg(16'h0000, -1, 1);
        checks += 2;
        if (link_up !== 1'b0) begin errors++; $display("FAIL relink_link_up got %b want 0", link_up); end
        if (an_state !== 3'd0) begin errors++; $display("FAIL relink_state got %0d want 0", an_state); end
    endtask

    task automatic test_count_restart();
        do_reset();
        send_cfg(16'h9801, -1, 1);
        send_cfg(16'h9801, -1, 1);
        send_cfg(16'h1801, -1, 1);
        checks += 1;
        if (an_state !== 3'd0) begin errors++; $display("FAIL restart_cnt_early got %0d want 0", an_state); end
        send_cfg(16'h1801, -1, 1);
        send_cfg(16'h1801, -1, 1);
        checks += 2;
        if (an_state !== 3'd1) begin errors++; $display("FAIL restart_cnt_state got %0d want 1", an_state); end
        if (partner_config !== 16'h1801) begin errors++; $display("FAIL restart_cnt_partner got %h want 1801", partner_config); end
    endtask

    task automatic test_code_err();
        do_reset();
        send_cfg(16'h9801, -1, 1);
        send_cfg(16'h9801, 2, 1);
        send_cfg(16'h9801, -1, 1);
        send_cfg(16'h9801, -1, 1);
        checks += 1;
        if (an_state !== 3'd0) begin errors++; $display("FAIL code_err_early got %0d want 0", an_state); end
        send_cfg(16'h9801, -1, 1);
        checks += 1;
        if (an_state !== 3'd1) begin errors++; $display("FAIL code_err_final got %0d want 1", an_state); end
    endtask

    task automatic test_restart_vs_ack();
        do_reset();
        repeat (3) send_cfg(16'h9801, -1, 1);
        repeat (2) send_cfg(16'hD801, -1, 1);
        send_cfg(16'hD801, -1, 0);
        @(posedge clock); #1;
        rx_valid = 1'b0; an_restart = 1'b1;
        checks += 1;
        if (config_valid !== 1'b1) begin errors++; $display("FAIL restart_align got %b want 1", config_valid); end
        model_clear(); m_state = 0;
        idle_cycles(5);
        checks += 3;
        if (an_state !== 3'd0) begin errors++; $display("FAIL restart_state got %0d want 0", an_state); end
        if (tx_ack !== 1'b0) begin errors++; $display("FAIL restart_tx_ack got %b want 0", tx_ack); end
        if (partner_config !== 16'h9801) begin errors++; $display("FAIL restart_partner got %h want 9801", partner_config); end
    endtask

    task automatic test_parser_k();
        int p0;
        do_reset();
        p0 = cfg_pulses;
        send_byte(8'hBC, 1, 0); send_byte(8'hB5, 0, 0);
        send_byte(8'hBC, 1, 0); send_byte(8'hB5, 0, 0); send_byte(8'h34, 0, 0); send_byte(8'h12, 0, 0);
        idle_cycles(5);
        checks += 1;
        if (cfg_pulses - p0 !== 1) begin errors++; $display("FAIL k_comma_restart got %0d want 1", cfg_pulses - p0); end
        p0 = cfg_pulses;
        send_byte(8'hBC, 1, 0); send_byte(8'h42, 0, 0); send_byte(8'h34, 0, 0); send_byte(8'h3C, 1, 0);
        send_byte(8'h12, 0, 0);
        idle_cycles(5);
        checks += 1;
        if (cfg_pulses - p0 !== 0) begin errors++; $display("FAIL k_other_discard got %0d want 0", cfg_pulses - p0); end
        p0 = cfg_pulses;
        send_byte(8'hBC, 1, 0); send_byte(8'hB5, 0, 0); send_byte(8'h34, 0, 0);
        send_byte(8'hBC, 1, 0); send_byte(8'h42, 0, 0); send_byte(8'h01, 0, 0); send_byte(8'h98, 0, 0);
        idle_cycles(5);
        checks += 1;
        if (cfg_pulses - p0 !== 1) begin errors++; $display("FAIL k_mid_cfg got %0d want 1", cfg_pulses - p0); end
    endtask

    task automatic test_reset_mid();
        int p0;
        test_ability_ack_link();
        send_byte(8'hBC, 1, 0); send_byte(8'hB5, 0, 0); send_byte(8'h00, 0, 0);
        @(posedge clock); #1;
        reset = 1'b1; rx_valid = 1'b0;
        @(posedge clock); #1;
        reset = 1'b0;
        m_state = 0; m_partner = 16'h0; model_clear();
        checks += 4;
        if (an_state !== 3'd0) begin errors++; $display("FAIL mid_reset_state got %0d want 0", an_state); end
        if (link_up !== 1'b0) begin errors++; $display("FAIL mid_reset_link got %b want 0", link_up); end
        if (tx_send_config !== 1'b1) begin errors++; $display("FAIL mid_reset_send got %b want 1", tx_send_config); end
        if (partner_config !== 16'h0) begin errors++; $display("FAIL mid_reset_partner got %h want 0000", partner_config); end
        p0 = cfg_pulses;
        send_byte(8'h00, 0, 0);
        idle_cycles(5);
        checks += 1;
        if (cfg_pulses - p0 !== 0) begin errors++; $display("FAIL mid_reset_discard got %0d want 0", cfg_pulses - p0); end
    endtask

    task automatic test_random();
        logic [15:0] pool [4];
        logic [15:0] w, last_w;
        int r;
        pool[0] = 16'h9801; pool[1] = 16'hD801; pool[2] = 16'h1801; pool[3] = 16'h0000;
        do_reset();
        gap_en = 1;
        m_cfg_count = cfg_pulses;
        last_w = 16'h9801;
        for (int it = 0; it < 60; it++) begin
            r = $urandom_range(0, 9);
            if (r < 6) begin
                if (m_state == 1 && $urandom_range(0, 1) == 1) w = m_partner | 16'h4000;
                else if ($urandom_range(0, 2) != 0) w = last_w;
                else w = pool[$urandom_range(0, 3)];
                send_cfg(w, -1, 1);
                last_w = w;
            end else if (r < 7) begin
                send_cfg(pool[$urandom_range(0, 3)], $urandom_range(0, 3), 1);
            end else if (r < 9) begin
                send_idle(-1);
            end else begin
                send_idle($urandom_range(0, 1));
            end
            checks += 6;
            if (an_state !== 3'(m_state)) begin errors++; $display("FAIL rnd_state it=%0d got %0d want %0d", it, an_state, m_state); end
            if (link_up !== (m_state == 4)) begin errors++; $display("FAIL rnd_link it=%0d got %b want %b", it, link_up, m_state == 4); end
            if (tx_send_config !== (m_state < 3)) begin errors++; $display("FAIL rnd_send it=%0d got %b want %b", it, tx_send_config, m_state < 3); end
            if (tx_ack !== (m_state == 1 || m_state == 2)) begin errors++; $display("FAIL rnd_ack it=%0d got %b want %b", it, tx_ack, m_state == 1); end
            if (partner_config !== m_partner) begin errors++; $display("FAIL rnd_partner it=%0d got %h want %h", it, partner_config, m_partner); end
            if (cfg_pulses !== m_cfg_count) begin errors++; $display("FAIL rnd_pulses it=%0d got %0d want %0d", it, cfg_pulses, m_cfg_count); end
        end
        gap_en = 0;
    endtask

    task automatic test_link_timer();
        int n;
        do_reset();
        repeat (3) send_cfg(16'h9801, -1, 1);
        repeat (2) send_cfg(16'hD801, -1, 1);
        t_ca = -1; t_lu = -1; arm = 1;
        send_cfg(16'hD801, -1, 0);
        n = 0;
        while (t_lu < 0 && n < 400) begin
            send_byte(8'hBC, 1, 0);
            send_byte(8'h50, 0, 0);
            n++;
        end
        idle_cycles(2);
        arm = 0;
        checks += 3;
        if (t_ca < 0) begin errors++; $display("FAIL timer_complete_seen got none want entry"); end
        if (t_lu < 0) begin errors++; $display("FAIL timer_link_up got timeout want link_up"); end
        if (t_ca >= 0 && t_lu >= 0 && (t_lu - t_ca) < 200) begin
            errors++; $display("FAIL timer_delay got %0d want >=200", t_lu - t_ca);
        end
    endtask

    initial begin
        reset = 1'b1; an_restart = 1'b0; rx_valid = 1'b0;
        rx_data = 8'h00; rx_is_k = 1'b0; rx_code_err = 1'b0;
        m_state = 0; m_partner = 16'h0; m_idle_run = 0;
        test_reset();
`ifdef SGMII_AN_LINK_TIMER_EN
        test_link_timer();
`else
        test_ability_ack_link();
        test_link_restart();
        test_count_restart();
        test_code_err();
        test_restart_vs_ack();
        test_parser_k();
        test_reset_mid();
        test_random();
`endif
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
